tmds_encoder: RTL and testbench

- Single-channel DVI/TMDS 8b/10b encoder: pixel byte plus control bits in, 10-bit TMDS symbol out, with running-disparity DC balancing.
- Sits on the transmit side, one instance per colour channel (B/G/R).
- Output feeds the existing 10:1 serializer directly. It is the inverse of the channel decode done behind the receiver, and lets the board source generated video rather than only forwarding received symbols.

---
 rtl/tmds_encoder.sv | 112 +++++++++++
 tb/tb_tmds_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// Single-channel DVI/TMDS 8b/10b encoder with running-disparity DC balancing.
// Two register stages: transition minimisation, then DC balance / control tokens.
module tmds_encoder #(
  parameter logic INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [1:0] ctl,
  input  logic [7:0] din,
  output logic [9:0] dout
);

  localparam logic [9:0] TokCtl00 = 10'b1101010100;
  localparam logic [9:0] TokCtl01 = 10'b0010101011;
  localparam logic [9:0] TokCtl10 = 10'b0101010100;
  localparam logic [9:0] TokCtl11 = 10'b1010101011;
  localparam logic [9:0] InvMask  = {10{INVERT}};

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, b[i]};
    end
    return ones;
  endfunction

  // q_m[8] = 1 marks the XOR chain, 0 the XNOR chain.
  function automatic logic [8:0] minimise(input logic [7:0] b);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones     = popcount8(b);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !b[0]);
    q        = '0;
    q[0]     = b[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Stage 1 registers
  logic [8:0] qm_q;
  logic       de_q;
  logic [1:0] ctl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      qm_q  <= '0;
      de_q  <= 1'b0;
      ctl_q <= 2'b00;
    end else begin
      qm_q  <= minimise(din);
      de_q  <= de;
      ctl_q <= ctl;
    end
  end

  // Stage 2: DC balance
  logic signed [4:0] cnt_q, cnt_d;
  logic [9:0]        dout_q;
  logic [9:0]        sym;
  logic [3:0]        n1, n0;
  logic signed [4:0] bal;
  logic              cnt_pos, cnt_neg;

  always_comb begin
    n1      = popcount8(qm_q[7:0]);
    n0      = 4'd8 - n1;
    bal     = $signed({1'b0, n1}) - $signed({1'b0, n0});
    cnt_pos = !cnt_q[4] && (cnt_q != 5'sd0);
    cnt_neg = cnt_q[4];
    sym     = TokCtl00;
    cnt_d   = '0;
    if (!de_q) begin
      unique case (ctl_q)
        2'b00: sym = TokCtl00;
        2'b01: sym = TokCtl01;
        2'b10: sym = TokCtl10;
        2'b11: sym = TokCtl11;
        default: sym = TokCtl00;
      endcase
      cnt_d = '0;
    end else if ((cnt_q == 5'sd0) || (n1 == n0)) begin
      sym   = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d = qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
    end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
      sym   = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - bal;
    end else begin
      sym   = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + bal;
    end
  end

  // Disparity tracks the uninverted symbol; inversion is only for P/N swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= TokCtl00 ^ InvMask;
      cnt_q  <= '0;
    end else begin
      dout_q <= sym ^ InvMask;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: hand vector table, reset sequences and a
// randomized run against a behavioural model; INVERT=0 and INVERT=1 checked together.
module tb_tmds_encoder;

  logic       clk;
  logic       rst;
  logic       de;
  logic [1:0] ctl;
  logic [7:0] din;
  logic [9:0] dout;
  logic [9:0] dout_inv;

  int checks;
  int errors;

  tmds_encoder #(.INVERT(1'b0)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .ctl  (ctl),
    .din  (din),
    .dout (dout)
  );

  tmds_encoder #(.INVERT(1'b1)) u_dut_inv (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .ctl  (ctl),
    .din  (din),
    .dout (dout_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] Tok0 = 10'b1101010100;

  // Model state: the input word waiting in the pipeline and the running disparity.
  logic       p_de;
  logic [1:0] p_ctl;
  logic [7:0] p_din;
  int         m_disp;
  logic [9:0] exp_sym;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_encode(input logic d, input logic [1:0] c, input logic [7:0] b,
                            output logic [9:0] sym);
    int         ones, n1, bal, q8;
    logic       xn;
    logic [7:0] qm;
    if (!d) begin
      case (c)
        2'b00: sym = 10'b1101010100;
        2'b01: sym = 10'b0010101011;
        2'b10: sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      m_disp = 0;
    end else begin
      ones  = $countones(b);
      xn    = (ones > 4) || (ones == 4 && b[0] == 1'b0);
      qm    = '0;
      qm[0] = b[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
      q8  = xn ? 0 : 1;
      n1  = $countones(qm);
      bal = n1 - (8 - n1);
      if (m_disp == 0 || bal == 0) begin
        sym    = {(q8 == 0), (q8 == 1), (q8 == 1) ? qm : ~qm};
        m_disp = m_disp + ((q8 == 1) ? bal : -bal);
      end else if ((m_disp > 0 && bal > 0) || (m_disp < 0 && bal < 0)) begin
        sym    = {1'b1, (q8 == 1), ~qm};
        m_disp = m_disp + 2 * q8 - bal;
      end else begin
        sym    = {1'b0, (q8 == 1), qm};
        m_disp = m_disp + bal - 2 * (1 - q8);
      end
    end
  endtask

  // One clock: drive inputs, advance the model over the edge, compare both builds.
  task automatic step(input logic r, input logic d, input logic [1:0] c, input logic [7:0] b);
    rst = r;
    de  = d;
    ctl = c;
    din = b;
    @(posedge clk);
    if (r) begin
      exp_sym = Tok0;
      m_disp  = 0;
      p_de    = 1'b0;
      p_ctl   = 2'b00;
      p_din   = 8'h00;
    end else begin
      ref_encode(p_de, p_ctl, p_din, exp_sym);
      p_de  = d;
      p_ctl = c;
      p_din = b;
    end
    #1;
    check("model", dout, exp_sym);
    check("model_inv", dout_inv, ~exp_sym);
  endtask

  typedef struct {
    logic       de;
    logic [1:0] ctl;
    logic [7:0] din;
    logic [9:0] exp;
  } vec_t;

  vec_t tab[13];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    de     = 1'b0;
    ctl    = 2'b00;
    din    = 8'h00;
    p_de   = 1'b0;
    p_ctl  = 2'b00;
    p_din  = 8'h00;
    m_disp = 0;

    // Reset held with live data on the inputs, then released into control period.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 2'b00, 8'hA5);
      check("reset_tok", dout, Tok0);
      check("reset_tok_inv", dout_inv, 10'b0010101011);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b00, 8'h00);
      check("post_reset_tok", dout, Tok0);
    end

    // Ignored fields carry junk: din in control rows, ctl in data rows.
    tab[0]  = '{1'b0, 2'b01, 8'hA5, 10'b0010101011};
    tab[1]  = '{1'b0, 2'b10, 8'h3C, 10'b0101010100};
    tab[2]  = '{1'b0, 2'b11, 8'hFF, 10'b1010101011};
    tab[3]  = '{1'b0, 2'b00, 8'h5A, 10'b1101010100};
    tab[4]  = '{1'b1, 2'b11, 8'h00, 10'b0100000000};
    tab[5]  = '{1'b1, 2'b01, 8'h00, 10'b1111111111};
    tab[6]  = '{1'b1, 2'b10, 8'h00, 10'b0100000000};
    tab[7]  = '{1'b0, 2'b00, 8'h77, 10'b1101010100};
    tab[8]  = '{1'b1, 2'b11, 8'hFF, 10'b1000000000};
    tab[9]  = '{1'b0, 2'b00, 8'h00, 10'b1101010100};
    tab[10] = '{1'b1, 2'b00, 8'h00, 10'b0100000000};
    tab[11] = '{1'b0, 2'b00, 8'h00, 10'b1101010100};
    tab[12] = '{1'b1, 2'b00, 8'h00, 10'b0100000000};

    for (int i = 0; i <= 13; i++) begin
      if (i < 13) step(1'b0, tab[i].de, tab[i].ctl, tab[i].din);
      else        step(1'b0, 1'b0, 2'b00, 8'h00);
      if (i >= 1) begin
        check($sformatf("tab%0d", i - 1), dout, tab[i-1].exp);
        check($sformatf("tab%0d_inv", i - 1), dout_inv, ~tab[i-1].exp);
      end
    end

    // Reset in the middle of a data period drops the in-flight symbols.
    step(1'b0, 1'b1, 2'b00, 8'h00);
    step(1'b0, 1'b1, 2'b00, 8'h00);
    step(1'b1, 1'b1, 2'b00, 8'hFF);
    check("mid_reset", dout, Tok0);
    step(1'b0, 1'b1, 2'b00, 8'h00);
    check("mid_reset_flush", dout, Tok0);
    step(1'b0, 1'b1, 2'b00, 8'h00);
    check("mid_reset_cnt0", dout, 10'b0100000000);
    step(1'b0, 1'b0, 2'b00, 8'h00);
    check("mid_reset_next", dout, 10'b1111111111);

    // de toggling every cycle: every data symbol starts from zero disparity.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i[0], 2'b01, 8'h00);
    end

    // Randomized run with occasional resets and bursty data periods.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
           2'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
